phase_accumulator_glide: RTL and testbench

//  Per-voice NCO front end: holds the phase accumulator that feeds the tone generators
//  (pulse, saw, triangle, noise) and advances it once per sample_clk tick.

---
 rtl/phase_accumulator_glide.sv | 128 ++++++++++++
 tb/tb_phase_accumulator_glide.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_accumulator_glide.sv
// ---------------------------------------------------------------------------
// phase_accumulator_glide
//
// Per-voice NCO front end. Holds the phase accumulator that feeds the tone
// generators and advances it once per sample_clk tick. The effective increment
// (cur_freq) slews toward tone_freq one LSB at a time at a programmable rate
// (portamento). A qualified sync_in clears the phase (hard sync). sync_out
// pulses for one clk after every tick on which the phase add carries out.
//
// Ports
//   clk          in   system clock
//   rst          in   synchronous reset, active high
//   sample_clk   in   one-clk-wide sample-rate enable
//   tone_freq    in   target phase increment
//   glide_rate   in   0 = jump immediately; N = one LSB step every N+1 ticks
//   test         in   high: hold accumulator at 0
//   en_sync      in   qualifies sync_in
//   sync_in      in   hard-sync request, sampled only on ticks
//   accumulator  out  registered phase
//   cur_freq     out  registered effective (gliding) increment
//   sync_out     out  one-clk pulse after a wrapping tick
// ---------------------------------------------------------------------------
module phase_accumulator_glide #(
   parameter int ACCUMULATOR_BITS = 24,
   parameter int FREQ_BITS        = 16,
   parameter int GLIDE_BITS       = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        sample_clk,
   input  logic [FREQ_BITS-1:0]        tone_freq,
   input  logic [GLIDE_BITS-1:0]       glide_rate,
   input  logic                        test,
   input  logic                        en_sync,
   input  logic                        sync_in,
   output logic [ACCUMULATOR_BITS-1:0] accumulator,
   output logic [FREQ_BITS-1:0]        cur_freq,
   output logic                        sync_out
);

   // Zero-extension width taking cur_freq up to the accumulator width plus carry.
   localparam int EXT_BITS = ACCUMULATOR_BITS + 1 - FREQ_BITS;

   typedef enum logic [1:0] {
      HOLD      = 2'd0,
      SLEW_UP   = 2'd1,
      SLEW_DOWN = 2'd2
   } glide_state_e;

   glide_state_e                  state_q,     state_d;
   logic [FREQ_BITS-1:0]          cur_freq_q,  cur_freq_d;
   logic [GLIDE_BITS-1:0]         glide_cnt_q, glide_cnt_d;
   logic [ACCUMULATOR_BITS-1:0]   acc_q,       acc_d;
   logic                          sync_out_q,  sync_out_d;

   logic [ACCUMULATOR_BITS:0]     add_sum;
   logic                          slew_up;

   always_comb begin
      state_d     = state_q;
      cur_freq_d  = cur_freq_q;
      glide_cnt_d = glide_cnt_q;
      acc_d       = acc_q;
      sync_out_d  = 1'b0;

      // The add always uses the pre-step increment, so the glide step taken on
      // this tick only affects phase from the following tick on.
      add_sum = {1'b0, acc_q} + {{EXT_BITS{1'b0}}, cur_freq_q};
      slew_up = (cur_freq_q < tone_freq);

      if (sample_clk) begin
         // Direction is recomputed every tick, so a retarget mid-glide simply
         // flips or keeps direction while the step counter carries over.
         if (glide_rate == '0) begin
            cur_freq_d  = tone_freq;
            state_d     = HOLD;
            glide_cnt_d = '0;
         end else if (cur_freq_q == tone_freq) begin
            state_d     = HOLD;
            glide_cnt_d = '0;
         end else if (glide_cnt_q >= glide_rate) begin
            // >= rather than == so lowering glide_rate below the running count
            // steps immediately instead of waiting for the counter to wrap.
            cur_freq_d  = slew_up ? (cur_freq_q + FREQ_BITS'(1))
                                  : (cur_freq_q - FREQ_BITS'(1));
            glide_cnt_d = '0;
            if (cur_freq_d == tone_freq)
               state_d = HOLD;
            else
               state_d = slew_up ? SLEW_UP : SLEW_DOWN;
         end else begin
            glide_cnt_d = glide_cnt_q + GLIDE_BITS'(1);
            state_d     = slew_up ? SLEW_UP : SLEW_DOWN;
         end

         if (test) begin
            acc_d = '0;
         end else if (en_sync && sync_in) begin
            // Sync wins over a simultaneous carry: no wrap pulse is emitted.
            acc_d = '0;
         end else begin
            acc_d      = add_sum[ACCUMULATOR_BITS-1:0];
            sync_out_d = add_sum[ACCUMULATOR_BITS];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= HOLD;
         cur_freq_q  <= '0;
         glide_cnt_q <= '0;
         acc_q       <= '0;
         sync_out_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cur_freq_q  <= cur_freq_d;
         glide_cnt_q <= glide_cnt_d;
         acc_q       <= acc_d;
         sync_out_q  <= sync_out_d;
      end
   end

   assign accumulator = acc_q;
   assign cur_freq    = cur_freq_q;
   assign sync_out    = sync_out_q;

endmodule

// File: tb/tb_phase_accumulator_glide.sv
// ---------------------------------------------------------------------------
// tb_phase_accumulator_glide
//
// Directed testbench for phase_accumulator_glide with default parameters
// (24-bit accumulator, 16-bit frequency, 8-bit glide rate). Inputs change on
// the falling edge; outputs are sampled on the falling edge after a tick.
// ---------------------------------------------------------------------------
module tb_phase_accumulator_glide;

   logic        clk;
   logic        rst;
   logic        sample_clk;
   logic [15:0] tone_freq;
   logic [7:0]  glide_rate;
   logic        test;
   logic        en_sync;
   logic        sync_in;
   logic [23:0] accumulator;
   logic [15:0] cur_freq;
   logic        sync_out;

   int checks   = 0;
   int failures = 0;

   phase_accumulator_glide #(
      .ACCUMULATOR_BITS(24),
      .FREQ_BITS       (16),
      .GLIDE_BITS      (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .sample_clk (sample_clk),
      .tone_freq  (tone_freq),
      .glide_rate (glide_rate),
      .test       (test),
      .en_sync    (en_sync),
      .sync_in    (sync_in),
      .accumulator(accumulator),
      .cur_freq   (cur_freq),
      .sync_out   (sync_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One sample tick: sample_clk high across exactly one rising edge.
   task automatic tick();
      @(negedge clk);
      sample_clk = 1'b1;
      @(negedge clk);
      sample_clk = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst        = 1'b1;
      sample_clk = 1'b1;
      tone_freq  = 16'h0000;
      glide_rate = 8'd0;
      test       = 1'b0;
      en_sync    = 1'b0;
      sync_in    = 1'b0;
      @(negedge clk);
      rst        = 1'b0;
      sample_clk = 1'b0;
   endtask

   // Builds accumulator = 0xFF0000 + 0xFF00 = 0xFFFF00 with cur_freq = 0x0200.
   task automatic setup_near_wrap();
      do_reset();
      tone_freq = 16'hFF00;
      tick();
      repeat (256) tick();
      tone_freq = 16'h0200;
      tick();
   endtask

   // Builds accumulator = 0x7F00 * 256 = 0x7F0000 with cur_freq = 0x7F00.
   task automatic setup_7f();
      do_reset();
      tone_freq = 16'h7F00;
      tick();
      repeat (256) tick();
   endtask

   task automatic test_reset();
      // Make some state first so the reset has something to clear.
      do_reset();
      tone_freq = 16'h1234;
      tick();
      tick();
      @(negedge clk);
      rst        = 1'b1;
      sample_clk = 1'b1;
      @(negedge clk);
      rst        = 1'b0;
      sample_clk = 1'b0;
      checks++;
      if (accumulator !== 24'h0) begin
         failures++;
         $display("FAIL reset_acc got=%h exp=%h", accumulator, 24'h0);
      end
      checks++;
      if (cur_freq !== 16'h0) begin
         failures++;
         $display("FAIL reset_freq got=%h exp=%h", cur_freq, 16'h0);
      end
      checks++;
      if (sync_out !== 1'b0) begin
         failures++;
         $display("FAIL reset_sync got=%b exp=0", sync_out);
      end
   endtask

   task automatic test_free_run();
      int early_pulses;
      logic [23:0] held;
      do_reset();
      tone_freq  = 16'h1000;
      glide_rate = 8'd0;
      tick();
      checks++;
      if (cur_freq !== 16'h1000 || accumulator !== 24'h0) begin
         failures++;
         $display("FAIL free_tick1 got freq=%h acc=%h exp freq=1000 acc=000000",
                  cur_freq, accumulator);
      end
      idle(2);
      tick();
      checks++;
      if (accumulator !== 24'h001000) begin
         failures++;
         $display("FAIL free_tick2 got=%h exp=%h", accumulator, 24'h001000);
      end
      held = accumulator;
      idle(3);
      checks++;
      if (accumulator !== held) begin
         failures++;
         $display("FAIL free_hold got=%h exp=%h", accumulator, held);
      end
      // Adds 2..4095 must not carry; add 4096 wraps to zero.
      early_pulses = 0;
      for (int i = 2; i < 4096; i++) begin
         tick();
         if (sync_out !== 1'b0) early_pulses++;
         idle(2);
      end
      checks++;
      if (early_pulses != 0) begin
         failures++;
         $display("FAIL free_early_sync got=%0d exp=0", early_pulses);
      end
      checks++;
      if (accumulator !== 24'hFFF000) begin
         failures++;
         $display("FAIL free_pre_wrap got=%h exp=%h", accumulator, 24'hFFF000);
      end
      tick();
      checks++;
      if (sync_out !== 1'b1 || accumulator !== 24'h0) begin
         failures++;
         $display("FAIL free_wrap got sync=%b acc=%h exp sync=1 acc=000000",
                  sync_out, accumulator);
      end
      idle(1);
      checks++;
      if (sync_out !== 1'b0) begin
         failures++;
         $display("FAIL free_sync_width got=%b exp=0", sync_out);
      end
   endtask

   task automatic test_glide();
      logic [15:0] exp_f;
      int bad;
      do_reset();
      tone_freq = 16'h0100;
      tick();
      tone_freq  = 16'h0104;
      glide_rate = 8'd2;
      tick();
      tick();
      checks++;
      if (cur_freq !== 16'h0100) begin
         failures++;
         $display("FAIL glide_tick2 got=%h exp=%h", cur_freq, 16'h0100);
      end
      tick();
      checks++;
      if (cur_freq !== 16'h0101) begin
         failures++;
         $display("FAIL glide_tick3 got=%h exp=%h", cur_freq, 16'h0101);
      end
      bad = 0;
      for (int k = 4; k <= 18; k++) begin
         tick();
         exp_f = (k >= 12) ? 16'h0104 : 16'(16'h0100 + k / 3);
         if (cur_freq !== exp_f) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL glide_ramp_hold got=%0d_bad final=%h exp=0_bad final=0104",
                  bad, cur_freq);
      end
      // Start up again, then retarget downward with the counter part-way.
      tone_freq = 16'h0108;
      repeat (3) tick();
      checks++;
      if (cur_freq !== 16'h0105) begin
         failures++;
         $display("FAIL glide_up2 got=%h exp=%h", cur_freq, 16'h0105);
      end
      tick();
      tone_freq = 16'h0100;
      tick();
      checks++;
      if (cur_freq !== 16'h0105) begin
         failures++;
         $display("FAIL glide_retarget_wait got=%h exp=%h", cur_freq, 16'h0105);
      end
      tick();
      checks++;
      if (cur_freq !== 16'h0104) begin
         failures++;
         $display("FAIL glide_retarget_down got=%h exp=%h", cur_freq, 16'h0104);
      end
      glide_rate = 8'd0;
      tone_freq  = 16'h0200;
      tick();
      checks++;
      if (cur_freq !== 16'h0200) begin
         failures++;
         $display("FAIL glide_rate0_jump got=%h exp=%h", cur_freq, 16'h0200);
      end
   endtask

   task automatic test_hard_sync();
      setup_7f();
      checks++;
      if (accumulator !== 24'h7F0000) begin
         failures++;
         $display("FAIL sync_setup got=%h exp=%h", accumulator, 24'h7F0000);
      end
      en_sync = 1'b1;
      sync_in = 1'b1;
      tick();
      sync_in = 1'b0;
      checks++;
      if (accumulator !== 24'h0 || sync_out !== 1'b0) begin
         failures++;
         $display("FAIL sync_clear got acc=%h sync=%b exp acc=000000 sync=0",
                  accumulator, sync_out);
      end
      setup_7f();
      en_sync = 1'b0;
      sync_in = 1'b1;
      tick();
      sync_in = 1'b0;
      checks++;
      if (accumulator !== 24'h7F7F00) begin
         failures++;
         $display("FAIL sync_disabled got=%h exp=%h", accumulator, 24'h7F7F00);
      end
   endtask

   task automatic test_wrap_vs_sync();
      setup_near_wrap();
      checks++;
      if (accumulator !== 24'hFFFF00 || cur_freq !== 16'h0200) begin
         failures++;
         $display("FAIL wrap_setup got acc=%h freq=%h exp acc=ffff00 freq=0200",
                  accumulator, cur_freq);
      end
      tick();
      checks++;
      if (accumulator !== 24'h000100 || sync_out !== 1'b1) begin
         failures++;
         $display("FAIL wrap_free got acc=%h sync=%b exp acc=000100 sync=1",
                  accumulator, sync_out);
      end
      idle(1);
      checks++;
      if (sync_out !== 1'b0) begin
         failures++;
         $display("FAIL wrap_pulse_width got=%b exp=0", sync_out);
      end
      setup_near_wrap();
      en_sync = 1'b1;
      sync_in = 1'b1;
      tick();
      sync_in = 1'b0;
      en_sync = 1'b0;
      checks++;
      if (accumulator !== 24'h0 || sync_out !== 1'b0) begin
         failures++;
         $display("FAIL wrap_with_sync got acc=%h sync=%b exp acc=000000 sync=0",
                  accumulator, sync_out);
      end
   endtask

   task automatic test_test_bit();
      int bad;
      do_reset();
      tone_freq = 16'h1000;
      tick();
      tick();
      test       = 1'b1;
      tone_freq  = 16'h1002;
      glide_rate = 8'd1;
      bad = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (accumulator !== 24'h0 || sync_out !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL test_hold got=%0d_bad acc=%h exp=0_bad acc=000000", bad, accumulator);
      end
      checks++;
      if (cur_freq !== 16'h1002) begin
         failures++;
         $display("FAIL test_glide got=%h exp=%h", cur_freq, 16'h1002);
      end
      test = 1'b0;
      tick();
      checks++;
      if (accumulator !== 24'h001002) begin
         failures++;
         $display("FAIL test_release got=%h exp=%h", accumulator, 24'h001002);
      end
   endtask

   initial begin
      rst        = 1'b1;
      sample_clk = 1'b0;
      tone_freq  = 16'h0;
      glide_rate = 8'd0;
      test       = 1'b0;
      en_sync    = 1'b0;
      sync_in    = 1'b0;
      idle(2);
      rst = 1'b0;
      test_reset();
      test_free_run();
      test_glide();
      test_hard_sync();
      test_wrap_vs_sync();
      test_test_bit();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
